// File: rtl/mips_dmem_responder.sv
// Data-memory responder: word SRAM window with wait states and bad-access flag.
// Optional write protection of the low words is enabled with `define MEM_PROTECT_EN.
module mips_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10000000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter int          PROT_WORDS  = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  mem_write_en,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        mem_excpt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] dout_q, dout_d;
  logic        exc_q, exc_d;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [29:0] src_addr;
  logic [31:0] src_data;
  logic [3:0]  src_mask;
  logic [29:0] idx;
  logic [DEPTH_LOG2-1:0] widx;
  logic        in_rng;
  logic        is_wr;
  logic        prot;
  logic        commit;
  logic        mem_we;
  logic [31:0] cur;
  logic [31:0] merged;

  // With zero wait states the commit edge is the accept edge,
  // so the live inputs stand in for the not-yet-latched ones.
  assign src_addr = (state_q == IDLE) ? mem_addr : addr_q;
  assign src_data = (state_q == IDLE) ? mem_data_in : wdata_q;
  assign src_mask = (state_q == IDLE) ? mem_write_en : mask_q;

  assign idx    = src_addr - BASE_ADDR[31:2];
  assign in_rng = (idx >> DEPTH_LOG2) == '0;
  assign widx   = idx[DEPTH_LOG2-1:0];
  assign is_wr  = src_mask != 4'b0000;
  assign cur    = mem[widx];

`ifdef MEM_PROTECT_EN
  assign prot = is_wr && (idx < 30'(PROT_WORDS));
`else
  assign prot = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = src_mask[i] ? src_data[8*i +: 8]
                                     : cur[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    dout_d  = dout_q;
    exc_d   = exc_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_data_in;
          mask_d  = mem_write_en;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        exc_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      if (!in_rng || prot) begin
        dout_d = '0;
        exc_d  = 1'b1;
      end else begin
        dout_d = is_wr ? merged : cur;
        exc_d  = 1'b0;
      end
    end
  end

  assign mem_we = rst_b && commit && in_rng && is_wr && !prot;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      dout_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      dout_q  <= dout_d;
      exc_q   <= exc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[widx] <= merged;
    end
  end

  assign mem_data_out = dout_q;
  assign mem_ready    = state_q == RESP;
  assign mem_excpt    = exc_q;
  assign busy         = state_q != IDLE;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder with a response scoreboard.
// Two instances: one wait state (function) and three (throughput).
module tb_mips_dmem_responder;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;

  logic        a_req = 1'b0;
  logic [29:0] a_addr = '0;
  logic [31:0] a_din = '0;
  logic [3:0]  a_we = '0;
  logic [31:0] a_dout;
  logic        a_ready, a_exc, a_busy;

  logic        b_req = 1'b0;
  logic [29:0] b_addr = '0;
  logic [31:0] b_din = '0;
  logic [3:0]  b_we = '0;
  logic [31:0] b_dout;
  logic        b_ready, b_exc, b_busy;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  mips_dmem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .mem_req(a_req),
    .mem_addr(a_addr), .mem_data_in(a_din),
    .mem_write_en(a_we), .mem_data_out(a_dout),
    .mem_ready(a_ready), .mem_excpt(a_exc),
    .busy(a_busy)
  );

  mips_dmem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .mem_req(b_req),
    .mem_addr(b_addr), .mem_data_in(b_din),
    .mem_write_en(b_we), .mem_data_out(b_dout),
    .mem_ready(b_ready), .mem_excpt(b_exc),
    .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [29:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] m);
    exp_t r;
    logic [29:0] idx;
    logic [31:0] old;
    idx = a - 30'h04000000;
    r.d = '0;
    r.e = 1'b1;
    if (idx >= 30'd1024) return r;
`ifdef MEM_PROTECT_EN
    if (m != 4'b0 && idx < 30'd64) return r;
`endif
    old = mdl.exists(int'(idx)) ? mdl[int'(idx)] : 32'h0;
    for (int i = 0; i < 4; i++)
      if (m[i]) old[8*i +: 8] = d[8*i +: 8];
    if (m != 4'b0) mdl[int'(idx)] = old;
    r.d = old;
    r.e = 1'b0;
    return r;
  endfunction

  task automatic xfer(input string tag,
                      input logic [29:0] a,
                      input logic [31:0] d,
                      input logic [3:0] m);
    exp_t e;
    int n;
    logic got;
    @(negedge clk);
    a_req = 1'b1;
    a_addr = a;
    a_din = d;
    a_we = m;
    q.push_back(model(a, d, m));
    @(posedge clk);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        a_req = 1'b0;
        a_addr = 30'h3ABCDEF0;
        a_din = $urandom;
        a_we = 4'hF;
      end
      if (a_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ready_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, n, 32'd2);
    e = q.pop_front();
    chk({tag, "_data"}, a_dout, e.d);
    chk({tag, "_excpt"}, 32'(a_exc), 32'(e.e));
    @(negedge clk);
  endtask

  initial begin
    int rdy_cnt;
    int busy_cnt;
    int first_rdy;
    int last_rdy;
    int gap_bad;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", a_dout, 32'h0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_excpt", 32'(a_exc), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    xfer("wr256", 30'h04000100, 32'h11223344, 4'hF);
    xfer("rd256", 30'h04000100, 32'h0, 4'h0);
    xfer("lane_wr", 30'h04000100, 32'hAABBCCDD, 4'b0101);
    chk("lane_model", mdl[256], 32'h11BB33DD);
    xfer("lane_rd", 30'h04000100, 32'h0, 4'h0);

    xfer("wr1023", 30'h040003FF, 32'hCAFEF00D, 4'hF);
    xfer("rd1023", 30'h040003FF, 32'h0, 4'h0);
    xfer("rd1024", 30'h04000400, 32'h0, 4'h0);
    xfer("rd_below", 30'h03FFFFFF, 32'h0, 4'h0);
    xfer("wr_oob", 30'h04000400, 32'h12345678, 4'hF);

    xfer("wr5", 30'h04000005, 32'h55555555, 4'hF);
    @(negedge clk);
    a_req = 1'b1;
    a_addr = 30'h04000005;
    a_din = 32'hDEADBEEF;
    a_we = 4'hF;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    a_req = 1'b0;
    #1;
    chk("mid_rst_dout", a_dout, 32'h0);
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_excpt", 32'(a_exc), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    xfer("rd5_after_rst", 30'h04000005, 32'h0, 4'h0);

    xfer("wr10", 30'h0400000A, 32'h0A0A0A0A, 4'hF);
`ifndef MEM_PROTECT_EN
    xfer("rd10", 30'h0400000A, 32'h0, 4'h0);
`endif
    xfer("wr64", 30'h04000040, 32'h64646464, 4'hF);
    xfer("rd64", 30'h04000040, 32'h0, 4'h0);

    @(negedge clk);
    b_req = 1'b1;
    b_addr = 30'h04000000;
    b_we = 4'h0;
    rdy_cnt = 0;
    busy_cnt = 0;
    first_rdy = 0;
    last_rdy = 0;
    gap_bad = 0;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (b_busy) busy_cnt++;
      if (b_ready) begin
        rdy_cnt++;
        if (first_rdy == 0) first_rdy = c;
        else if (c - last_rdy != 5) gap_bad++;
        last_rdy = c;
      end
    end
    b_req = 1'b0;
    chk("tput_ready_count", rdy_cnt, 32'd3);
    chk("tput_first_ready", first_rdy, 32'd4);
    chk("tput_gap_errors", gap_bad, 32'd0);
    chk("tput_busy_cycles", busy_cnt, 32'd12);
    repeat (6) @(negedge clk);
    chk("tput_idle_busy", 32'(b_busy), 32'd0);
    chk("sb_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
